// File: rtl/cdb_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// Packages for the CDB scheduler slice.
//   uarch_pkg         : shared micro-architecture types (writeback packet,
//                       pipeline width, writeback requester indices).
//   cdb_scheduler_pkg : scheduler-local constants and helpers.
// Optional feature macro used by the scheduler: CDB_SCHED_PERF_EN.
// -----------------------------------------------------------------------------
package uarch_pkg;

  localparam int PIPE_WIDTH = 2;
  localparam int NUM_WB_REQ = 4;

  typedef enum logic [1:0] {
    WB_ALU0 = 2'd0,
    WB_ALU1 = 2'd1,
    WB_MDU  = 2'd2,
    WB_DMEM = 2'd3
  } wb_req_idx_e;

  typedef struct packed {
    logic [4:0]  rob_idx;
    logic [5:0]  prd;
    logic [31:0] data;
    logic        exc;
  } writeback_packet_t;

endpackage

package cdb_scheduler_pkg;
  import uarch_pkg::*;

  localparam int PERF_W = 32;

  // Index width that stays legal for a single-entry vector.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdb_scheduler_if.sv
// -----------------------------------------------------------------------------
// Writeback/CDB bundle between execute-stage requesters and the scheduler.
//   flush     : pipeline flush from ROB
//   wb_req    : per-requester writeback request
//   wb_pkt    : per-requester result packet
//   wb_gnt    : combinational grant back to requesters
//   cdb_ports : registered CDB payload, one per port
//   cdb_valid : registered per-port valid
// master = requester / ROB side, slave = scheduler.
// -----------------------------------------------------------------------------
interface cdb_scheduler_if
  import uarch_pkg::*;
#(
  parameter int NUM_REQ    = uarch_pkg::NUM_WB_REQ,
  parameter int PIPE_WIDTH = uarch_pkg::PIPE_WIDTH
);
  logic                                  flush;
  logic              [NUM_REQ-1:0]       wb_req;
  writeback_packet_t [NUM_REQ-1:0]       wb_pkt;
  logic              [NUM_REQ-1:0]       wb_gnt;
  writeback_packet_t [PIPE_WIDTH-1:0]    cdb_ports;
  logic              [PIPE_WIDTH-1:0]    cdb_valid;

  modport master (
    output flush, wb_req, wb_pkt,
    input  wb_gnt, cdb_ports, cdb_valid
  );

  modport slave (
    input  flush, wb_req, wb_pkt,
    output wb_gnt, cdb_ports, cdb_valid
  );
endinterface

// File: rtl/cdb_scheduler_rr_multi_picker.sv
// -----------------------------------------------------------------------------
// rr_multi_picker: combinational circular scan that picks up to PIPE_WIDTH
// requesters starting at i_start.
//   i_req      : request vector
//   i_start    : first index to scan
//   o_gnt      : grant vector
//   o_sel      : per-port one-hot select (port k = k-th grantee in scan order)
//   o_last     : index of the last grantee
//   o_any      : at least one grant issued
// -----------------------------------------------------------------------------
module rr_multi_picker
  import cdb_scheduler_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int PIPE_WIDTH = 2,
  localparam int PTR_W     = idx_w(NUM_REQ),
  localparam int PORT_W    = idx_w(PIPE_WIDTH),
  localparam int CNT_W     = $clog2(PIPE_WIDTH + 1)
) (
  input  logic [NUM_REQ-1:0]                  i_req,
  input  logic [PTR_W-1:0]                    i_start,
  output logic [NUM_REQ-1:0]                  o_gnt,
  output logic [PIPE_WIDTH-1:0][NUM_REQ-1:0]  o_sel,
  output logic [PTR_W-1:0]                    o_last,
  output logic                                o_any
);

  logic [PTR_W:0]   w_sum;
  logic [PTR_W-1:0] w_idx;
  logic [CNT_W-1:0] w_cnt;

  always_comb begin
    o_gnt  = '0;
    o_sel  = '0;
    o_last = '0;
    w_cnt  = '0;
    w_sum  = '0;
    w_idx  = '0;
    for (int o = 0; o < NUM_REQ; o++) begin
      // Explicit mod NUM_REQ so non-power-of-2 sizes wrap correctly.
      w_sum = {1'b0, i_start} + (PTR_W+1)'(o);
      if (w_sum >= (PTR_W+1)'(NUM_REQ)) w_sum = w_sum - (PTR_W+1)'(NUM_REQ);
      w_idx = w_sum[PTR_W-1:0];
      if (i_req[w_idx] && (w_cnt < CNT_W'(PIPE_WIDTH))) begin
        o_gnt[w_idx]                     = 1'b1;
        o_sel[w_cnt[PORT_W-1:0]][w_idx]  = 1'b1;
        o_last                           = w_idx;
        w_cnt                            = w_cnt + 1'b1;
      end
    end
    o_any = |o_gnt;
  end

endmodule

// File: rtl/cdb_scheduler.sv
// -----------------------------------------------------------------------------
// cdb_scheduler: round-robin sharing of PIPE_WIDTH CDB ports among NUM_REQ
// writeback requesters. Grants are combinational; granted packets appear on
// the registered CDB slots one cycle later.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : cdb_scheduler_if.slave (flush, wb_req/wb_pkt/wb_gnt,
//               cdb_ports/cdb_valid)
//   perf_*    : 32-bit saturating counters, only with CDB_SCHED_PERF_EN
// -----------------------------------------------------------------------------
module cdb_scheduler
  import uarch_pkg::*;
  import cdb_scheduler_pkg::*;
#(
  parameter int NUM_REQ    = uarch_pkg::NUM_WB_REQ,
  parameter int PIPE_WIDTH = uarch_pkg::PIPE_WIDTH,
  localparam int PTR_W     = idx_w(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  cdb_scheduler_if.slave       bus
`ifdef CDB_SCHED_PERF_EN
  ,
  output logic [PERF_W-1:0]    perf_grant_cnt,
  output logic [PERF_W-1:0]    perf_conflict_cnt,
  output logic [PERF_W-1:0]    perf_idle_cnt
`endif
);

  logic [PTR_W-1:0]                    r_rr_ptr;
  logic [NUM_REQ-1:0]                  w_req_eff;
  logic [NUM_REQ-1:0]                  w_gnt;
  logic [PIPE_WIDTH-1:0][NUM_REQ-1:0]  w_sel;
  logic [PTR_W-1:0]                    w_last;
  logic                                w_any;
  writeback_packet_t [PIPE_WIDTH-1:0]  w_port_pkt;
  logic [PIPE_WIDTH-1:0]               w_fill;

  // Reset and flush both suppress all grants by hiding the requests.
  assign w_req_eff = (rst || bus.flush) ? '0 : bus.wb_req;

  rr_multi_picker #(
    .NUM_REQ    (NUM_REQ),
    .PIPE_WIDTH (PIPE_WIDTH)
  ) u_picker (
    .i_req   (w_req_eff),
    .i_start (r_rr_ptr),
    .o_gnt   (w_gnt),
    .o_sel   (w_sel),
    .o_last  (w_last),
    .o_any   (w_any)
  );

  assign bus.wb_gnt = w_gnt;

  always_comb begin
    w_port_pkt = '0;
    w_fill     = '0;
    for (int k = 0; k < PIPE_WIDTH; k++) begin
      w_fill[k] = |w_sel[k];
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_sel[k][i]) w_port_pkt[k] = bus.wb_pkt[i];
      end
    end
  end

  // Grant -> CDB register stage; unfilled ports keep their old payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr      <= '0;
      bus.cdb_valid <= '0;
      bus.cdb_ports <= '0;
    end else begin
      bus.cdb_valid <= w_fill;
      for (int k = 0; k < PIPE_WIDTH; k++) begin
        if (w_fill[k]) bus.cdb_ports[k] <= w_port_pkt[k];
      end
      if (w_any) begin
        r_rr_ptr <= (w_last == PTR_W'(NUM_REQ - 1)) ? '0 : w_last + 1'b1;
      end
    end
  end

`ifdef CDB_SCHED_PERF_EN
  function automatic logic [PERF_W-1:0] sat_add(input logic [PERF_W-1:0] a,
                                                input logic [PERF_W-1:0] b);
    logic [PERF_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[PERF_W] ? {PERF_W{1'b1}} : s[PERF_W-1:0];
  endfunction

  logic [PERF_W-1:0] w_gnt_num;
  logic              w_conflict;
  logic              w_idle;

  assign w_gnt_num  = PERF_W'($countones(w_gnt));
  assign w_conflict = ($countones(bus.wb_req) > PIPE_WIDTH);
  assign w_idle     = (bus.wb_req == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_grant_cnt    <= '0;
      perf_conflict_cnt <= '0;
      perf_idle_cnt     <= '0;
    end else if (!bus.flush) begin
      perf_grant_cnt    <= sat_add(perf_grant_cnt, w_gnt_num);
      perf_conflict_cnt <= sat_add(perf_conflict_cnt, PERF_W'(w_conflict));
      perf_idle_cnt     <= sat_add(perf_idle_cnt, PERF_W'(w_idle));
    end
  end
`endif

endmodule

// File: tb/tb_cdb_scheduler.sv
module tb_cdb_scheduler;
  import uarch_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  cdb_scheduler_if #(.NUM_REQ(4), .PIPE_WIDTH(2)) bus ();

`ifdef CDB_SCHED_PERF_EN
  logic [31:0] perf_grant_cnt, perf_conflict_cnt, perf_idle_cnt;
`endif

  cdb_scheduler #(.NUM_REQ(4), .PIPE_WIDTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef CDB_SCHED_PERF_EN
    ,
    .perf_grant_cnt    (perf_grant_cnt),
    .perf_conflict_cnt (perf_conflict_cnt),
    .perf_idle_cnt     (perf_idle_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic writeback_packet_t mk_pkt(input int i);
    writeback_packet_t p;
    p.rob_idx = 5'(i + 3);
    p.prd     = 6'(i + 10);
    p.data    = 32'hA5A0_0000 + 32'(i * 17);
    p.exc     = i[0];
    return p;
  endfunction

  // Apply inputs on the falling edge; grants are sampled 1 time unit later.
  task automatic drive(input logic [3:0] req, input logic fl, input logic r);
    @(negedge clk);
    bus.wb_req = req;
    bus.flush  = fl;
    rst        = r;
    #1;
  endtask

  task automatic post_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      drive(4'b1111, 1'b0, 1'b1);
      checks++;
      if (bus.wb_gnt !== 4'b0000) begin errors++; $display("FAIL rst_gnt got %b want %b", bus.wb_gnt, 4'b0000); end
      post_edge();
      checks++;
      if (bus.cdb_valid !== 2'b00) begin errors++; $display("FAIL rst_valid got %b want %b", bus.cdb_valid, 2'b00); end
    end
    checks++;
    if (bus.cdb_ports[0] !== writeback_packet_t'(0)) begin errors++; $display("FAIL rst_port0 got %h want 0", bus.cdb_ports[0]); end
    drive(4'b1111, 1'b0, 1'b0);
    checks++;
    if (bus.wb_gnt !== 4'b0011) begin errors++; $display("FAIL rst_rel_gnt got %b want %b", bus.wb_gnt, 4'b0011); end
    post_edge();
    checks++;
    if (bus.cdb_valid !== 2'b11) begin errors++; $display("FAIL rst_rel_valid got %b want %b", bus.cdb_valid, 2'b11); end
    checks++;
    if (bus.cdb_ports[0] !== mk_pkt(0) || bus.cdb_ports[1] !== mk_pkt(1)) begin
      errors++; $display("FAIL rst_rel_ports got %h %h want %h %h", bus.cdb_ports[0], bus.cdb_ports[1], mk_pkt(0), mk_pkt(1));
    end
  endtask

  task automatic test_fairness();
    logic [3:0] exp_g [4];
    int         exp_p [4][2];
    exp_g = '{4'b0011, 4'b1100, 4'b0011, 4'b1100};
    exp_p = '{'{0, 1}, '{2, 3}, '{0, 1}, '{2, 3}};
    drive(4'b1111, 1'b0, 1'b1);
    for (int c = 0; c < 4; c++) begin
      drive(4'b1111, 1'b0, 1'b0);
      checks++;
      if (bus.wb_gnt !== exp_g[c]) begin errors++; $display("FAIL fair_gnt%0d got %b want %b", c, bus.wb_gnt, exp_g[c]); end
      post_edge();
      checks++;
      if (bus.cdb_ports[0] !== mk_pkt(exp_p[c][0]) || bus.cdb_ports[1] !== mk_pkt(exp_p[c][1]) || bus.cdb_valid !== 2'b11) begin
        errors++; $display("FAIL fair_ports%0d got %h %h v%b want %h %h v11", c, bus.cdb_ports[0], bus.cdb_ports[1], bus.cdb_valid, mk_pkt(exp_p[c][0]), mk_pkt(exp_p[c][1]));
      end
    end
  endtask

  task automatic test_single_none();
    drive(4'b0100, 1'b0, 1'b0);
    checks++;
    if (bus.wb_gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt got %b want %b", bus.wb_gnt, 4'b0100); end
    post_edge();
    checks++;
    if (bus.cdb_valid !== 2'b01 || bus.cdb_ports[0] !== mk_pkt(WB_MDU)) begin
      errors++; $display("FAIL single_port got v%b %h want v01 %h", bus.cdb_valid, bus.cdb_ports[0], mk_pkt(WB_MDU));
    end
    checks++;
    if (bus.cdb_ports[1] !== mk_pkt(WB_DMEM)) begin errors++; $display("FAIL single_hold1 got %h want %h", bus.cdb_ports[1], mk_pkt(WB_DMEM)); end
    drive(4'b0000, 1'b0, 1'b0);
    checks++;
    if (bus.wb_gnt !== 4'b0000) begin errors++; $display("FAIL none_gnt got %b want %b", bus.wb_gnt, 4'b0000); end
    post_edge();
    checks++;
    if (bus.cdb_valid !== 2'b00) begin errors++; $display("FAIL none_valid got %b want %b", bus.cdb_valid, 2'b00); end
  endtask

  // Pointer is 3 here (after MDU grant, held through the idle cycle).
  task automatic test_wrap();
    drive(4'b1001, 1'b0, 1'b0);
    checks++;
    if (bus.wb_gnt !== 4'b1001) begin errors++; $display("FAIL wrap_gnt got %b want %b", bus.wb_gnt, 4'b1001); end
    post_edge();
    checks++;
    if (bus.cdb_ports[0] !== mk_pkt(WB_DMEM) || bus.cdb_ports[1] !== mk_pkt(WB_ALU0) || bus.cdb_valid !== 2'b11) begin
      errors++; $display("FAIL wrap_ports got %h %h v%b want %h %h v11", bus.cdb_ports[0], bus.cdb_ports[1], bus.cdb_valid, mk_pkt(WB_DMEM), mk_pkt(WB_ALU0));
    end
    drive(4'b1111, 1'b0, 1'b0);
    checks++;
    if (bus.wb_gnt !== 4'b0110) begin errors++; $display("FAIL wrap_ptr_gnt got %b want %b", bus.wb_gnt, 4'b0110); end
    post_edge();
    checks++;
    if (bus.cdb_ports[0] !== mk_pkt(WB_ALU1) || bus.cdb_ports[1] !== mk_pkt(WB_MDU)) begin
      errors++; $display("FAIL wrap_ptr_ports got %h %h want %h %h", bus.cdb_ports[0], bus.cdb_ports[1], mk_pkt(WB_ALU1), mk_pkt(WB_MDU));
    end
  endtask

  // Pointer is 3 on entry.
  task automatic test_flush();
    drive(4'b1111, 1'b1, 1'b0);
    checks++;
    if (bus.wb_gnt !== 4'b0000) begin errors++; $display("FAIL flush_gnt got %b want %b", bus.wb_gnt, 4'b0000); end
    post_edge();
    checks++;
    if (bus.cdb_valid !== 2'b00) begin errors++; $display("FAIL flush_valid got %b want %b", bus.cdb_valid, 2'b00); end
    drive(4'b1111, 1'b0, 1'b0);
    checks++;
    if (bus.wb_gnt !== 4'b1001) begin errors++; $display("FAIL flush_ptr_gnt got %b want %b", bus.wb_gnt, 4'b1001); end
    drive(4'b0000, 1'b1, 1'b0);
    checks++;
    if (bus.cdb_valid !== 2'b11 || bus.cdb_ports[0] !== mk_pkt(WB_DMEM)) begin
      errors++; $display("FAIL flush_after_gnt got v%b %h want v11 %h", bus.cdb_valid, bus.cdb_ports[0], mk_pkt(WB_DMEM));
    end
    post_edge();
    checks++;
    if (bus.cdb_valid !== 2'b00) begin errors++; $display("FAIL flush_clear got %b want %b", bus.cdb_valid, 2'b00); end
    drive(4'b1111, 1'b1, 1'b1);
    checks++;
    if (bus.wb_gnt !== 4'b0000) begin errors++; $display("FAIL flush_rst_gnt got %b want %b", bus.wb_gnt, 4'b0000); end
    post_edge();
    drive(4'b1111, 1'b0, 1'b0);
    checks++;
    if (bus.wb_gnt !== 4'b0011) begin errors++; $display("FAIL flush_rst_ptr got %b want %b", bus.wb_gnt, 4'b0011); end
    post_edge();
  endtask

`ifdef CDB_SCHED_PERF_EN
  task automatic test_perf();
    drive(4'b1111, 1'b0, 1'b1);
    for (int c = 0; c < 10; c++) drive(4'b1111, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++)  drive(4'b0000, 1'b0, 1'b0);
    post_edge();
    checks++;
    if (perf_grant_cnt !== 32'd20) begin errors++; $display("FAIL perf_grant got %0d want 20", perf_grant_cnt); end
    checks++;
    if (perf_conflict_cnt !== 32'd10) begin errors++; $display("FAIL perf_conflict got %0d want 10", perf_conflict_cnt); end
    checks++;
    if (perf_idle_cnt !== 32'd5) begin errors++; $display("FAIL perf_idle got %0d want 5", perf_idle_cnt); end
  endtask
`endif

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    bus.flush  = 1'b0;
    bus.wb_req = 4'b1111;
    for (int i = 0; i < 4; i++) bus.wb_pkt[i] = mk_pkt(i);
    test_reset();
    test_fairness();
    test_single_none();
    test_wrap();
    test_flush();
`ifdef CDB_SCHED_PERF_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
